sdram_read_engine: RTL and testbench
====================================

// Module: sdram_read_engine
// PURPOSE
//  Slave side of sdram_read_intf; sits directly downstream of sdram_read_mux.
//  Accepts one read job (start address + word count), splits it into Avalon-MM
//  bursts of at most MAX_BURST words, and streams returned words back as
//  read_valid/read_data. Flags completion with a read_done pulse.
//  One job at a time; one burst outstanding at a time.
// PARAMETERS
//  DATA_W     32  word width in bits; byte address stride per word = DATA_W/8
//  MAX_BURST  8   max Avalon burstcount per burst; power of 2, 1..64
//  BC_W       $clog2(MAX_BURST)+1  width of avm_burstcount
// PORTS
//  clk                input   1       single clock, all logic rising-edge
//  rst                input   1       asynchronous reset, active-high
//  read_addr          input   32      job start byte address, sampled on read_start
//  read_cnt           input   11      job length in words (0..2047), sampled on read_start
//  read_start         input   1       1-cycle job request pulse
//  read_valid         output  1       read_data holds a valid word this cycle
//  read_data          output  DATA_W  returned word, in address order
//  read_done          output  1       1-cycle pulse: job complete
//  avm_address        output  32      burst start byte address
//  avm_read           output  1       Avalon read command
//  avm_burstcount     output  BC_W    words in current burst
//  avm_waitrequest    input   1       slave stall; command held while high
//  avm_readdata       input   DATA_W  returned word
//  avm_readdatavalid  input   1       avm_readdata valid
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; read_valid, read_done,
//   avm_read = 0; read_data, avm_address, avm_burstcount = 0; counters = 0.
//  All outputs are registered.
//  IDLE:
//   - read_start=1 latches addr/cnt.
//   - cnt==0 -> DONE (no bus activity); else -> ISSUE.
//   - read_start outside IDLE is ignored. No queueing.
//  ISSUE:
//   - avm_read=1, avm_address=cur_addr, avm_burstcount=min(remaining, MAX_BURST).
//   - All three are stable while avm_waitrequest=1.
//   - Cycle with avm_read=1 and waitrequest=0 = accepted:
//     avm_read drops next cycle; cur_addr += burstcount*DATA_W/8 (32-bit wrap,
//     no carry out); remaining -= burstcount; beat_cnt = burstcount; -> WAIT.
//  WAIT:
//   - Each avm_readdatavalid=1: read_valid=1 and read_data=avm_readdata on the
//     next cycle (fixed 1-cycle latency, no backpressure); beat_cnt--.
//   - On the last beat: remaining==0 -> DONE, else -> ISSUE.
//   - The next avm_read asserts the cycle after the last beat is captured.
//  DONE: read_done=1 for exactly one cycle, same cycle as the final read_valid
//   (or the cycle after read_start when cnt==0); -> IDLE.
//   A new read_start is accepted the cycle after read_done.
//  readdatavalid outside WAIT is dropped and does not generate read_valid.
//  Bursts do not split at page/row boundaries; the SDRAM controller handles that.
//  Reset mid-job: bus command abandoned immediately; no read_done;
//   late readdatavalid after reset is ignored (state=IDLE).
//  read_cnt=2047 with MAX_BURST=8: 255 bursts of 8 then one burst of 7.
// TESTING
//  1. addr=0x1000,cnt=4,no stalls -> one burst bc=4 @0x1000; 4 read_valid in order;
//     read_done coincides with the 4th.
//  2. addr=0x2000,cnt=20,MAX_BURST=8 -> bursts bc=8@0x2000, 8@0x2020, 4@0x2040;
//     exactly 20 read_valid; one read_done.
//  3. waitrequest high 5 cycles during ISSUE -> address/burstcount/read stable
//     throughout; single acceptance; data correct.
//  4. cnt=0 -> no avm_read ever; read_done pulses the cycle after read_start.
//  5. read_start re-pulsed mid-job with a different addr -> ignored; original job
//     completes; a new start is accepted right after read_done.
//  6. rst asserted during WAIT after 3 of 8 beats -> outputs 0 immediately;
//     no read_done; remaining beats produce no read_valid; next job runs normally.
//  7. addr=0xFFFFFFF8,cnt=4,DATA_W=32 -> 2nd burst address wraps to 0x00000000
//     (MAX_BURST=2).

Source files
------------

// File: rtl/sdram_read_engine_if.sv
// rtl/sdram_read_engine_if.sv - job request/response and Avalon-MM burst read signals
interface sdram_read_engine_if #(
  parameter int DATA_W = 32,
  parameter int BC_W   = 4
);
  logic [31:0]       read_addr;
  logic [10:0]       read_cnt;
  logic              read_start;
  logic              read_valid;
  logic [DATA_W-1:0] read_data;
  logic              read_done;
  logic [31:0]       avm_address;
  logic              avm_read;
  logic [BC_W-1:0]   avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport slave (
    input  read_addr, read_cnt, read_start,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output read_valid, read_data, read_done,
    output avm_address, avm_read, avm_burstcount
  );

  modport master (
    output read_addr, read_cnt, read_start,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  read_valid, read_data, read_done,
    input  avm_address, avm_read, avm_burstcount
  );
endinterface

// File: rtl/sdram_read_engine.sv
// rtl/sdram_read_engine.sv - splits a read job into Avalon-MM bursts and streams the words back
// One job and one outstanding burst at a time; every output comes straight from a register.
module sdram_read_engine #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int BC_W      = $clog2(MAX_BURST) + 1
) (
  input logic                 clk,
  input logic                 rst,
  sdram_read_engine_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [31:0]     BYTES  = 32'(DATA_W / 8);
  localparam logic [BC_W-1:0] MAX_BC = BC_W'(MAX_BURST);

  state_t            state_q, state_d;
  logic [31:0]       cur_addr_q, cur_addr_d;
  logic [10:0]       remaining_q, remaining_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic              avm_read_q, avm_read_d;
  logic [31:0]       avm_address_q, avm_address_d;
  logic [BC_W-1:0]   avm_bc_q, avm_bc_d;
  logic              read_valid_q, read_valid_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_done_q, read_done_d;

  function automatic logic [BC_W-1:0] burst_len(input logic [10:0] rem);
    return (rem >= 11'(MAX_BURST)) ? MAX_BC : rem[BC_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      beat_cnt_q    <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= '0;
      avm_bc_q      <= '0;
      read_valid_q  <= 1'b0;
      read_data_q   <= '0;
      read_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      beat_cnt_q    <= beat_cnt_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      avm_bc_q      <= avm_bc_d;
      read_valid_q  <= read_valid_d;
      read_data_q   <= read_data_d;
      read_done_q   <= read_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    beat_cnt_d    = beat_cnt_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    avm_bc_d      = avm_bc_q;
    read_valid_d  = 1'b0;
    read_data_d   = read_data_q;
    read_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.read_start) begin
          cur_addr_d  = bus.read_addr;
          remaining_d = bus.read_cnt;
          if (bus.read_cnt == '0) begin
            read_done_d = 1'b1;
            state_d     = DONE;
          end else begin
            avm_read_d    = 1'b1;
            avm_address_d = bus.read_addr;
            avm_bc_d      = burst_len(bus.read_cnt);
            state_d       = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!bus.avm_waitrequest) begin
          avm_read_d  = 1'b0;
          cur_addr_d  = avm_address_q + 32'(avm_bc_q) * BYTES;
          remaining_d = remaining_q - 11'(avm_bc_q);
          beat_cnt_d  = avm_bc_q;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus.avm_readdatavalid) begin
          read_valid_d = 1'b1;
          read_data_d  = bus.avm_readdata;
          beat_cnt_d   = beat_cnt_q - BC_W'(1);
          // Last beat: either finish the job or line up the next burst with no idle cycle.
          if (beat_cnt_q == BC_W'(1)) begin
            if (remaining_q == '0) begin
              read_done_d = 1'b1;
              state_d     = DONE;
            end else begin
              avm_read_d    = 1'b1;
              avm_address_d = cur_addr_q;
              avm_bc_d      = burst_len(remaining_q);
              state_d       = ISSUE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.read_valid     = read_valid_q;
  assign bus.read_data      = read_data_q;
  assign bus.read_done      = read_done_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_burstcount = avm_bc_q;
endmodule

// File: tb/tb_sdram_read_engine.sv
// tb/tb_sdram_read_engine.sv - randomized bench for sdram_read_engine with a queue-based reference model
module tb_sdram_read_engine;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int BC_W      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_read_engine_if #(.DATA_W(DATA_W), .BC_W(BC_W)) bus();

  sdram_read_engine #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .BC_W(BC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected bursts and words of the accepted job
  logic [31:0] exp_baddr[$];
  int          exp_bbc[$];
  logic [31:0] exp_words[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic model_job(input logic [31:0] a, input int n);
    int left;
    int b;
    logic [31:0] p;
    for (int i = 0; i < n; i++) exp_words.push_back(mem_word(a + 32'(4 * i)));
    left = n;
    p = a;
    while (left > 0) begin
      b = (left > MAX_BURST) ? MAX_BURST : left;
      exp_baddr.push_back(p);
      exp_bbc.push_back(b);
      p = p + 32'(b * 4);
      left = left - b;
    end
  endtask

  // Avalon slave: random stalls, random gaps between beats, occasional stray readdatavalid
  int          beats_left = 0;
  logic [31:0] beat_addr = '0;
  bit          stale = 0;
  bit          no_stall = 0;
  int          force_wait = 0;
  bit          beat_real = 0;
  bit          last_beat_drv = 0;

  initial begin
    bit          acc;
    bit          rd;
    logic [31:0] a;
    int          bc;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    forever begin
      @(negedge clk);
      acc = bus.avm_read && !bus.avm_waitrequest && !rst;
      rd  = bus.avm_read;
      a   = bus.avm_address;
      bc  = int'(bus.avm_burstcount);
      @(posedge clk);
      #1;
      if (acc) begin
        beats_left = bc;
        beat_addr  = a;
      end
      if (force_wait > 0 && rd) force_wait--;
      bus.avm_waitrequest = no_stall ? 1'b0 : (force_wait > 0) ? 1'b1 : ($urandom_range(0, 9) < 4);
      bus.avm_readdatavalid = 1'b0;
      beat_real = 0;
      last_beat_drv = 0;
      if (beats_left > 0 && (no_stall || $urandom_range(0, 9) < 7)) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = mem_word(beat_addr);
        beat_real  = !stale;
        beat_addr  = beat_addr + 32'd4;
        beats_left--;
        last_beat_drv = (beats_left == 0) && !stale;
        if (beats_left == 0) stale = 0;
      end else if (beats_left == 0 && !no_stall && $urandom_range(0, 19) == 0) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = $urandom;
      end
    end
  end

  // Compare process: checks every cycle against the model queues
  int done_cnt = 0;
  int valid_cnt = 0;
  bit zero_pend = 0;
  bit zero_seen = 0;

  initial begin
    bit              prev_real = 0;
    bit              prev_last = 0;
    bit              prev_acc = 0;
    bit              prev_rw = 0;
    logic [31:0]     prev_addr = '0;
    logic [BC_W-1:0] prev_bc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_ctrl", {bus.read_valid, bus.read_done, bus.avm_read, bus.avm_burstcount}, 0);
        check("rst_addr", bus.avm_address, 0);
        check("rst_data", bus.read_data, 0);
        prev_real = 0; prev_last = 0; prev_acc = 0; prev_rw = 0;
      end else begin
        check("read_valid_latency", bus.read_valid, prev_real);
        if (bus.read_valid) begin
          valid_cnt++;
          if (exp_words.size() == 0) check("unexpected_word", bus.read_valid, 0);
          else begin
            check("read_data", bus.read_data, exp_words.pop_front());
            check("read_done_last", bus.read_done, exp_words.size() == 0);
          end
        end else if (zero_pend) begin
          check("zero_job_done", bus.read_done, zero_seen);
          if (zero_seen) zero_pend = 0;
          zero_seen = 1;
        end else begin
          check("read_done_idle", bus.read_done, 0);
        end
        if (bus.read_done) done_cnt++;
        if (prev_rw) begin
          check("hold_read", bus.avm_read, 1);
          check("hold_addr", bus.avm_address, prev_addr);
          check("hold_bc", bus.avm_burstcount, prev_bc);
        end
        if (prev_acc) check("read_drop", bus.avm_read, 0);
        if (prev_last && exp_baddr.size() > 0) check("reissue_next_cycle", bus.avm_read, 1);
        prev_acc = bus.avm_read && !bus.avm_waitrequest;
        if (prev_acc) begin
          if (exp_baddr.size() == 0) check("unexpected_burst", bus.avm_read, 0);
          else begin
            check("burst_addr", bus.avm_address, exp_baddr.pop_front());
            check("burst_cnt", bus.avm_burstcount, exp_bbc.pop_front());
          end
        end
        prev_rw   = bus.avm_read && bus.avm_waitrequest;
        prev_addr = bus.avm_address;
        prev_bc   = bus.avm_burstcount;
        prev_real = bus.avm_readdatavalid && beat_real;
        prev_last = last_beat_drv;
      end
    end
  end

  // Main stimulus; every action happens 1 time unit after a rising edge
  task automatic start_job(input logic [31:0] a, input int n, input bit model);
    bus.read_addr  = a;
    bus.read_cnt   = 11'(n);
    bus.read_start = 1'b1;
    if (model) begin
      model_job(a, n);
      if (n == 0) begin
        zero_seen = 0;
        zero_pend = 1;
      end
    end
    @(posedge clk); #1;
    bus.read_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int b = budget;
    while (done_cnt == d0 && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
  endtask

  task automatic run_job(input string name, input logic [31:0] a, input int n);
    int d0 = done_cnt;
    int v0 = valid_cnt;
    start_job(a, n, 1);
    wait_done(d0, 20000);
    check({name, "_done"}, done_cnt - d0, 1);
    check({name, "_words"}, valid_cnt - v0, n);
  endtask

  initial begin
    int d0, v0, b;
    bus.read_addr = '0;
    bus.read_cnt = '0;
    bus.read_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single short burst, no stalls
    no_stall = 1;
    d0 = done_cnt; v0 = valid_cnt;
    start_job(32'h0000_1000, 4, 1);
    @(negedge clk);
    check("t1_read", bus.avm_read, 1);
    check("t1_addr", bus.avm_address, 32'h0000_1000);
    check("t1_bc", bus.avm_burstcount, 4);
    @(posedge clk); #1;
    wait_done(d0, 200);
    check("t1_done", done_cnt - d0, 1);
    check("t1_words", valid_cnt - v0, 4);
    no_stall = 0;

    // 2: three bursts, model pinned against hand values
    d0 = done_cnt; v0 = valid_cnt;
    start_job(32'h0000_2000, 20, 1);
    check("t2_nbursts", exp_baddr.size(), 3);
    check("t2_b0", {exp_baddr[0], 32'(exp_bbc[0])}, {32'h0000_2000, 32'd8});
    check("t2_b1", {exp_baddr[1], 32'(exp_bbc[1])}, {32'h0000_2020, 32'd8});
    check("t2_b2", {exp_baddr[2], 32'(exp_bbc[2])}, {32'h0000_2040, 32'd4});
    wait_done(d0, 2000);
    check("t2_done", done_cnt - d0, 1);
    check("t2_words", valid_cnt - v0, 20);

    // 3: waitrequest held for five cycles of ISSUE
    force_wait = 5;
    d0 = done_cnt; v0 = valid_cnt;
    start_job(32'h0000_3000, 6, 1);
    repeat (5) begin
      @(negedge clk);
      check("t3_stall_read", bus.avm_read, 1);
      check("t3_stall_addr", bus.avm_address, 32'h0000_3000);
    end
    @(posedge clk); #1;
    wait_done(d0, 2000);
    check("t3_done", done_cnt - d0, 1);
    check("t3_words", valid_cnt - v0, 6);

    // 4: zero-length job
    d0 = done_cnt;
    start_job(32'h0000_4000, 0, 1);
    @(negedge clk);
    check("t4_done_pulse", bus.read_done, 1);
    repeat (4) begin
      @(negedge clk);
      check("t4_no_read", bus.avm_read, 0);
    end
    @(posedge clk); #1;
    check("t4_done", done_cnt - d0, 1);

    // 5: start re-pulsed mid-job is ignored; back-to-back start after read_done
    d0 = done_cnt; v0 = valid_cnt;
    start_job(32'h0000_5000, 16, 1);
    repeat (3) begin @(posedge clk); #1; end
    start_job(32'h0000_6000, 5, 0);
    wait_done(d0, 2000);
    check("t5_done", done_cnt - d0, 1);
    check("t5_words", valid_cnt - v0, 16);
    d0 = done_cnt;
    start_job(32'h0000_7000, 3, 1);
    @(negedge clk);
    check("t5_restart_read", bus.avm_read, 1);
    check("t5_restart_addr", bus.avm_address, 32'h0000_7000);
    @(posedge clk); #1;
    wait_done(d0, 2000);
    check("t5_second_done", done_cnt - d0, 1);

    // 6: reset in WAIT after three of eight beats
    no_stall = 1;
    d0 = done_cnt; v0 = valid_cnt;
    start_job(32'h0000_8000, 8, 1);
    b = 200;
    while (valid_cnt - v0 < 3 && b > 0) begin
      @(negedge clk); #1;
      b--;
    end
    check("t6_three_beats", valid_cnt - v0, 3);
    rst = 1'b1;
    #1;
    check("t6_async_ctrl", {bus.read_valid, bus.read_done, bus.avm_read, bus.avm_burstcount}, 0);
    check("t6_async_data", bus.read_data, 0);
    exp_words.delete(); exp_baddr.delete(); exp_bbc.delete();
    stale = (beats_left > 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b = 200;
    while (beats_left > 0 && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    repeat (3) begin @(posedge clk); #1; end
    check("t6_no_more_words", valid_cnt - v0, 3);
    check("t6_no_done", done_cnt - d0, 0);
    no_stall = 0;
    run_job("t6_next", 32'h0000_9000, 10);

    // 7: address wraps past 0xFFFFFFFF
    d0 = done_cnt; v0 = valid_cnt;
    start_job(32'hFFFF_FFE0, 12, 1);
    check("t7_wrap_model", exp_baddr[1], 32'h0000_0000);
    wait_done(d0, 2000);
    check("t7_done", done_cnt - d0, 1);
    check("t7_words", valid_cnt - v0, 12);

    // Maximum job length
    d0 = done_cnt; v0 = valid_cnt;
    start_job(32'h0010_0000, 2047, 1);
    check("max_nbursts", exp_baddr.size(), 256);
    check("max_last_bc", exp_bbc[255], 7);
    wait_done(d0, 30000);
    check("max_done", done_cnt - d0, 1);
    check("max_words", valid_cnt - v0, 2047);

    // Random jobs
    for (int i = 0; i < 12; i++) begin
      run_job("rand", $urandom & 32'hFFFF_FFFC, $urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
